// File: rtl/lane_demux_loader.sv
// Steers one 64-bit lane per accepted transfer into the next of 12 lane registers.
// A full or in_last-terminated block is then held on block_out until block_ready.
module lane_demux_loader #(
    parameter int LANE_W    = 64,
    parameter int NUM_LANES = 12,
    parameter int IDX_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANE_W-1:0]           in_lane,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [LANE_W*NUM_LANES-1:0] block_out,
    output logic                        block_valid,
    input  logic                        block_ready,
    output logic [IDX_W-1:0]            lane_count
);

    localparam logic [IDX_W-1:0] NUM_LANES_L = IDX_W'(NUM_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_LANES - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_lane_count;
    logic [LANE_W-1:0]  r_lane [NUM_LANES];

    logic               w_xfer;
    logic               w_done;
    logic               w_release;
    logic [IDX_W-1:0]   w_idx_eff;
    logic [IDX_W-1:0]   w_idx_inc;

    // An out-of-range index is treated as lane 0 so no word is ever dropped.
    assign w_idx_eff = (r_idx < NUM_LANES_L) ? r_idx : '0;
    assign w_idx_inc = w_idx_eff + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        w_done      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_FILL: begin
                w_xfer = in_valid;
                if (in_valid && ((w_idx_eff == LAST_IDX) || in_last)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (block_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // Leaving HOLD clears every lane, so unwritten lanes of a short block read as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_lane[k] <= '0;
            end
        end else if (w_release) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_lane[k] <= '0;
            end
        end else if (w_xfer) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (w_idx_eff == IDX_W'(k)) begin
                    r_lane[k] <= in_lane;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_lane_count <= '0;
        end else if (w_release) begin
            r_idx        <= '0;
            r_lane_count <= '0;
        end else if (w_done) begin
            r_idx        <= '0;
            r_lane_count <= w_idx_inc;
        end else if (w_xfer) begin
            r_idx        <= w_idx_inc;
        end else if (r_idx >= NUM_LANES_L) begin
            r_idx        <= '0;
        end
    end

    assign in_ready    = (r_state == S_FILL);
    assign block_valid = (r_state == S_HOLD);
    assign lane_count  = r_lane_count;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_block_out
        assign block_out[g*LANE_W +: LANE_W] = r_lane[g];
    end

endmodule

// File: tb/tb_lane_demux_loader.sv
// Directed-vector bench for lane_demux_loader; inputs change and outputs are sampled on the falling edge.
module tb_lane_demux_loader;

    logic         clk;
    logic         rst;
    logic [63:0]  in_lane;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [767:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic [3:0]   lane_count;

    int checks;
    int errors;

    lane_demux_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_lane    (in_lane),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .block_out  (block_out),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .lane_count (lane_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_lane  = 64'h5555_0000 + 64'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL reset_block_valid: got %b expected 0", block_valid); end
        checks++; if (lane_count !== 4'd0) begin errors++; $display("FAIL reset_lane_count: got %0d expected 0", lane_count); end
        checks++; if (block_out !== 768'd0) begin errors++; $display("FAIL reset_block_out: got nonzero expected 0"); end
        #1 rst = 1'b0;
    endtask

    task automatic test_full_block();
        logic [63:0] got;
        block_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b1 || block_valid !== 1'b0) begin errors++; $display("FAIL full_fill_flags lane %0d: got rdy=%b vld=%b expected rdy=1 vld=0", i, in_ready, block_valid); end
            if (i > 0) begin
                got = block_out[(i-1)*64 +: 64];
                checks++; if (got !== 64'(i)) begin errors++; $display("FAIL full_write_latency lane %0d: got %h expected %h", i-1, got, 64'(i)); end
            end
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_lane  = 64'(i + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL full_block_valid: got %b expected 1", block_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_hold: got %b expected 0", in_ready); end
        checks++; if (lane_count !== 4'd12) begin errors++; $display("FAIL full_lane_count: got %0d expected 12", lane_count); end
        checks++; if (block_out[63:0] !== 64'd1) begin errors++; $display("FAIL full_lane0: got %h expected 1", block_out[63:0]); end
        checks++; if (block_out[767:704] !== 64'd12) begin errors++; $display("FAIL full_lane11: got %h expected c", block_out[767:704]); end
        @(negedge clk);
        checks++; if (block_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL full_release: got vld=%b rdy=%b expected vld=0 rdy=1", block_valid, in_ready); end
        checks++; if (lane_count !== 4'd0 || block_out !== 768'd0) begin errors++; $display("FAIL full_cleared: got count=%0d expected 0 with zero block", lane_count); end
        block_ready = 1'b0;
    endtask

    task automatic test_short_block();
        logic [63:0] got;
        logic [63:0] exp;
        block_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = (i == 4);
            in_lane  = 64'hA5A5_A5A5_A5A5_A5A0 + 64'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL short_block_valid: got %b expected 1", block_valid); end
        checks++; if (lane_count !== 4'd5) begin errors++; $display("FAIL short_lane_count: got %0d expected 5", lane_count); end
        for (int k = 0; k < 12; k++) begin
            exp = (k < 5) ? 64'hA5A5_A5A5_A5A5_A5A0 + 64'(k) : 64'd0;
            got = block_out[k*64 +: 64];
            checks++; if (got !== exp) begin errors++; $display("FAIL short_lane %0d: got %h expected %h", k, got, exp); end
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL short_release: got %b expected 0", block_valid); end
    endtask

    task automatic test_backpressure();
        logic [767:0] exp_blk;
        logic [767:0] exp_one;
        exp_blk = '0;
        block_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_lane  = 64'h1000 + 64'(i);
            exp_blk[i*64 +: 64] = 64'h1000 + 64'(i);
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0 || block_valid !== 1'b1) begin errors++; $display("FAIL bp_flags cycle %0d: got rdy=%b vld=%b expected rdy=0 vld=1", j, in_ready, block_valid); end
            checks++; if (block_out !== exp_blk) begin errors++; $display("FAIL bp_block_stable cycle %0d: got lane0=%h expected lane0=%h", j, block_out[63:0], exp_blk[63:0]); end
            in_valid = 1'b1;
            in_lane  = 64'hDEAD_0000 + 64'(j);
        end
        @(negedge clk);
        checks++; if (lane_count !== 4'd12) begin errors++; $display("FAIL bp_lane_count: got %0d expected 12", lane_count); end
        block_ready = 1'b1;
        in_lane     = 64'hBEEF_0001;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || block_out !== 768'd0) begin errors++; $display("FAIL bp_release: got rdy=%b lane0=%h expected rdy=1 lane0=0", in_ready, block_out[63:0]); end
        block_ready = 1'b0;
        in_lane     = 64'hBEEF_0002;
        in_last     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_one  = '0;
        exp_one[63:0] = 64'hBEEF_0002;
        checks++; if (block_valid !== 1'b1 || lane_count !== 4'd1) begin errors++; $display("FAIL bp_next_block: got vld=%b count=%0d expected vld=1 count=1", block_valid, lane_count); end
        checks++; if (block_out !== exp_one) begin errors++; $display("FAIL bp_next_lane0: got %h expected %h", block_out[63:0], exp_one[63:0]); end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
    endtask

    task automatic test_gapped();
        logic [63:0] got;
        int sent;
        int cyc;
        sent = 0;
        cyc  = 0;
        block_ready = 1'b0;
        while (sent < 12 && cyc < 100) begin
            @(negedge clk);
            checks++; if (block_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL gap_fill_flags cycle %0d: got vld=%b rdy=%b expected vld=0 rdy=1", cyc, block_valid, in_ready); end
            if ((cyc % 3) == 0) begin
                in_valid = 1'b1;
                in_lane  = 64'hC000 + 64'(sent);
                sent++;
            end else begin
                in_valid = 1'b0;
                in_lane  = 64'hBAD0_0000 + 64'(cyc);
            end
            cyc++;
        end
        checks++; if (sent != 12) begin errors++; $display("FAIL gap_timeout: got %0d lanes expected 12", sent); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (block_valid !== 1'b1 || lane_count !== 4'd12) begin errors++; $display("FAIL gap_done: got vld=%b count=%0d expected vld=1 count=12", block_valid, lane_count); end
        for (int k = 0; k < 12; k++) begin
            got = block_out[k*64 +: 64];
            checks++; if (got !== 64'hC000 + 64'(k)) begin errors++; $display("FAIL gap_lane %0d: got %h expected %h", k, got, 64'hC000 + 64'(k)); end
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        logic [63:0] got;
        block_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_lane  = 64'hEEEE_0000 + 64'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (block_out !== 768'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL midfill_reset: got rdy=%b lane0=%h expected rdy=1 lane0=0", in_ready, block_out[63:0]); end
        #1 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_lane  = 64'h7700 + 64'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (block_valid !== 1'b1 || lane_count !== 4'd12) begin errors++; $display("FAIL midfill_block: got vld=%b count=%0d expected vld=1 count=12", block_valid, lane_count); end
        for (int k = 0; k < 12; k++) begin
            got = block_out[k*64 +: 64];
            checks++; if (got !== 64'h7700 + 64'(k)) begin errors++; $display("FAIL midfill_lane %0d: got %h expected %h", k, got, 64'h7700 + 64'(k)); end
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        in_lane     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        block_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_full_block();
        test_short_block();
        test_backpressure();
        test_gapped();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
